// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: op/cond codes, FSM states and condition evaluation shared by the branch controller.
package branch_ctrl_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int STACK_DEPTH_DEF = 8;
  typedef enum logic [1:0] {OP_JMP, OP_CALL, OP_RET, OP_INT} op_e;
  typedef enum logic [2:0] {COND_AL, COND_EQ, COND_NE, COND_LT, COND_GT, COND_LE, COND_GE, COND_NV} cond_e;
  typedef enum logic [1:0] {IDLE, EVAL, POP} state_e;
  function automatic logic cond_met(cond_e c, logic lt, logic gt, logic eq);
    case (c)
      COND_AL: return 1'b1;
      COND_EQ: return eq;
      COND_NE: return !eq;
      COND_LT: return lt;
      COND_GT: return gt;
      COND_LE: return lt | eq;
      COND_GE: return gt | eq;
      default: return 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: decoder/fetch-facing bundle of the branch controller.
interface branch_ctrl_if #(parameter int ADDR_W = 16, parameter int STACK_DEPTH = 8);
  localparam int DW = $clog2(STACK_DEPTH) + 1;
  logic              start;
  logic [1:0]        op;
  logic [2:0]        cond;
  logic              lt;
  logic              gt;
  logic              eq;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_ret;
  logic              clr_err;
  logic              busy;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_out;
  logic              done;
  logic              taken;
  logic              stk_ovf;
  logic              stk_unf;
  logic [DW-1:0]     depth;
  modport master (output start, op, cond, lt, gt, eq, target, pc_ret, clr_err,
                  input busy, pc_load, pc_out, done, taken, stk_ovf, stk_unf, depth);
  modport slave (input start, op, cond, lt, gt, eq, target, pc_ret, clr_err,
                 output busy, pc_load, pc_out, done, taken, stk_ovf, stk_unf, depth);
endinterface

// File: rtl/branch_ctrl_ret_stack.sv
// ret_stack: return-address LIFO with registered read data; overflow/underflow are silently ignored here.
module ret_stack #(
  parameter int W = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] depth
);
  logic [W-1:0] mem [DEPTH];
  logic [DW-1:0] sp, sp_m1;
  assign sp_m1 = sp - 1'b1;
  assign full = sp == DW'(DEPTH);
  assign empty = sp == '0;
  assign depth = sp;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sp <= '0;
      rdata <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_m1;
      rdata <= mem[sp_m1[AW-1:0]];
    end
  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (push && !full) mem[sp[AW-1:0]] <= wdata;
endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: resolves conditional JMP/CALL/RET/INT against comparer flags and emits a one-shot PC load.
module branch_ctrl import branch_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input logic        clk,
  input logic        rst,
  branch_ctrl_if.slave bus
);
  state_e st, nxt;
  op_e op_q;
  cond_e cond_q;
  logic lt_q, gt_q, eq_q, ok, push, pop, full, empty, set_ovf, set_unf, ovf, unf;
  logic [ADDR_W-1:0] target_q, pc_ret_q, rdata;
  ret_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) stk (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .wdata(pc_ret_q),
    .rdata(rdata), .full(full), .empty(empty), .depth(bus.depth)
  );
  assign ok = op_q == OP_INT || cond_met(cond_q, lt_q, gt_q, eq_q);
  assign bus.busy = st != IDLE;
  assign bus.stk_ovf = ovf;
  assign bus.stk_unf = unf;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      op_q <= OP_JMP;
      cond_q <= COND_AL;
      {lt_q, gt_q, eq_q} <= '0;
      target_q <= '0;
      pc_ret_q <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && bus.start) begin
        op_q <= op_e'(bus.op);
        cond_q <= cond_e'(bus.cond);
        {lt_q, gt_q, eq_q} <= {bus.lt, bus.gt, bus.eq};
        target_q <= bus.target;
        pc_ret_q <= bus.pc_ret;
      end
      // clr_err takes priority over a same-cycle failed push/pop
      ovf <= !bus.clr_err && (ovf || set_ovf);
      unf <= !bus.clr_err && (unf || set_unf);
    end
  always_comb begin
    nxt = st;
    push = 1'b0;
    pop = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_out = '0;
    bus.done = 1'b0;
    bus.taken = 1'b0;
    case (st)
      IDLE: nxt = bus.start ? EVAL : IDLE;
      EVAL: begin
        nxt = IDLE;
        bus.done = 1'b1;
        if (ok)
          case (op_q)
            OP_JMP: {bus.pc_load, bus.taken, bus.pc_out} = {2'b11, target_q};
            OP_CALL, OP_INT:
              if (full) set_ovf = 1'b1;
              else {push, bus.pc_load, bus.taken, bus.pc_out} = {3'b111, target_q};
            OP_RET:
              if (empty) set_unf = 1'b1;
              else {pop, nxt, bus.done} = {1'b1, POP, 1'b0};
          endcase
      end
      POP: {nxt, bus.pc_load, bus.done, bus.taken, bus.pc_out} = {IDLE, 3'b111, rdata};
      default: nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: table vectors, corner sequences and random ops checked against a queue-based model.
module tb_branch_ctrl;
  localparam int AW = 16;
  localparam int SD = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  branch_ctrl_if #(.ADDR_W(AW), .STACK_DEPTH(SD)) bus ();
  branch_ctrl #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_tests = 0;
  int n_fail = 0;
  int unsigned mstk[$];
  bit m_ovf, m_unf;
  typedef struct {
    int op; int cond; bit lt; bit gt; bit eq; int target; int pc_ret;
    bit exp_taken; int exp_pc; int exp_depth;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit rule(input int c, input bit lt, input bit gt, input bit eq);
    case (c)
      0: return 1'b1;
      1: return eq;
      2: return !eq;
      3: return lt;
      4: return gt;
      5: return lt || eq;
      6: return gt || eq;
      default: return 1'b0;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.op = 2'd0; bus.cond = 3'd0;
    bus.lt = 1'b0; bus.gt = 1'b0; bus.eq = 1'b0;
    bus.target = '0; bus.pc_ret = '0; bus.clr_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mstk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(negedge clk);
    bus.clr_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check("clr_ovf", bus.stk_ovf, 0);
    check("clr_unf", bus.stk_unf, 0);
  endtask

  task automatic run_op(input int op, input int cond, input bit lt, input bit gt, input bit eq,
                        input int target, input int pc_ret,
                        output bit o_taken, output int o_pc, output int o_depth);
    bit e_taken;
    int e_pc, e_lat, done_cyc, load_cyc, loads;
    e_taken = 1'b0; e_pc = 0; e_lat = 1;
    if (op == 3 || rule(cond, lt, gt, eq)) begin
      if (op == 0) begin
        e_taken = 1'b1; e_pc = target;
      end else if (op == 2) begin
        if (mstk.size() == 0) m_unf = 1'b1;
        else begin e_pc = int'(mstk.pop_back()); e_taken = 1'b1; e_lat = 2; end
      end else begin
        if (mstk.size() == SD) m_ovf = 1'b1;
        else begin mstk.push_back(pc_ret); e_taken = 1'b1; e_pc = target; end
      end
    end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'(op); bus.cond = 3'(cond);
    bus.lt = lt; bus.gt = gt; bus.eq = eq;
    bus.target = 16'(target); bus.pc_ret = 16'(pc_ret);
    @(negedge clk);
    bus.start = 1'b0;
    done_cyc = 0; load_cyc = 0; loads = 0; o_pc = 0; o_taken = 1'b0;
    for (int c = 1; c <= 4 && done_cyc == 0; c++) begin
      if (bus.pc_load) begin loads++; load_cyc = c; o_pc = int'(bus.pc_out); end
      if (bus.done) begin done_cyc = c; o_taken = bus.taken; end
      if (done_cyc == 0) @(negedge clk);
    end
    check("done_seen", done_cyc != 0, 1);
    check("done_lat", done_cyc, e_lat);
    check("taken", o_taken, e_taken);
    check("pc_load_cnt", loads, e_taken);
    if (e_taken) begin
      check("pc_load_lat", load_cyc, e_lat);
      check("pc_out", o_pc, e_pc);
    end
    @(negedge clk);
    o_depth = int'(bus.depth);
    check("depth", o_depth, mstk.size());
    check("busy_after", bus.busy, 0);
    check("pulses_low", {bus.pc_load, bus.done, bus.taken}, 0);
    check("stk_ovf", bus.stk_ovf, m_ovf);
    check("stk_unf", bus.stk_unf, m_unf);
  endtask

  initial begin
    bit tk;
    int pc, dp, dones, loads, lpc;
    vt[0]  = '{0, 1, 0, 0, 1, 'h0120, 0,      1, 'h0120, 0};
    vt[1]  = '{0, 5, 0, 1, 0, 'h0400, 0,      0, 0,      0};
    vt[2]  = '{1, 0, 0, 0, 0, 'h0200, 'h0011, 1, 'h0200, 1};
    vt[3]  = '{2, 0, 0, 0, 0, 0,      0,      1, 'h0011, 0};
    vt[4]  = '{3, 7, 0, 0, 0, 'h0300, 'h0055, 1, 'h0300, 1};
    vt[5]  = '{0, 7, 1, 1, 1, 'h0777, 0,      0, 0,      1};
    vt[6]  = '{2, 6, 0, 1, 0, 0,      0,      1, 'h0055, 0};
    vt[7]  = '{0, 4, 1, 0, 0, 'h0888, 0,      0, 0,      0};
    vt[8]  = '{0, 2, 0, 0, 0, 'h1234, 0,      1, 'h1234, 0};
    vt[9]  = '{1, 3, 0, 1, 0, 'h0999, 'h0aaa, 0, 0,      0};
    vt[10] = '{1, 5, 0, 0, 1, 'h0abc, 'h0def, 1, 'h0abc, 1};
    vt[11] = '{2, 2, 0, 0, 1, 0,      0,      0, 0,      1};
    vt[12] = '{2, 3, 1, 0, 0, 0,      0,      1, 'h0def, 0};
    do_reset();
    @(negedge clk);
    check("rst_outputs", {bus.busy, bus.pc_load, bus.done, bus.taken, bus.stk_ovf, bus.stk_unf}, 0);
    check("rst_depth", bus.depth, 0);
    check("rst_pc_out", bus.pc_out, 0);

    for (int i = 0; i < 13; i++) begin
      run_op(vt[i].op, vt[i].cond, vt[i].lt, vt[i].gt, vt[i].eq, vt[i].target, vt[i].pc_ret, tk, pc, dp);
      check($sformatf("tbl%0d_taken", i), tk, vt[i].exp_taken);
      if (vt[i].exp_taken) check($sformatf("tbl%0d_pc", i), pc, vt[i].exp_pc);
      check($sformatf("tbl%0d_depth", i), dp, vt[i].exp_depth);
    end

    for (int i = 0; i < 9; i++) run_op(1, 0, 0, 0, 0, 'h0200 + i, 'h1000 + i, tk, pc, dp);
    check("ovf_taken", tk, 0);
    check("ovf_flag", bus.stk_ovf, 1);
    check("ovf_depth", bus.depth, 8);
    clear_errs();
    for (int i = 7; i >= 0; i--) begin
      run_op(2, 0, 0, 0, 0, 0, 0, tk, pc, dp);
      check("lifo_pc", pc, 'h1000 + i);
    end

    run_op(2, 0, 0, 0, 0, 0, 0, tk, pc, dp);
    check("unf_flag", bus.stk_unf, 1);
    check("unf_taken", tk, 0);
    clear_errs();

    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd0; bus.cond = 3'd0; bus.target = 16'h0abc;
    dones = 0; loads = 0; lpc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (bus.pc_load) begin loads++; lpc = int'(bus.pc_out); end
      bus.target = 16'h0bbb;
      if (c == 1) bus.start = 1'b0;
    end
    check("busy_done_cnt", dones, 1);
    check("busy_load_cnt", loads, 1);
    check("busy_pc", lpc, 'h0abc);

    do_reset();
    run_op(1, 0, 0, 0, 0, 'h0500, 'h0066, tk, pc, dp);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.cond = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("pop_pre_busy", bus.busy, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rstpop_pc_load", bus.pc_load, 0);
    check("rstpop_done", bus.done, 0);
    check("rstpop_busy", bus.busy, 0);
    check("rstpop_depth", bus.depth, 0);
    loads = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.pc_load || bus.done) loads++;
    end
    check("rstpop_no_pulse", loads, 0);
    rst = 1'b1;
    mstk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;

    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      run_op(r < 2 ? 0 : r < 5 ? 1 : r < 8 ? 2 : 3, int'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 16'hffff)), int'($urandom_range(0, 16'hffff)), tk, pc, dp);
      if ($urandom_range(0, 19) == 0) clear_errs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
